// File: rtl/csd_feed_sequencer_if.sv
// Stream and array-edge signal bundle for csd_feed_sequencer.
//   master : SRAM-side producer / bench; drives s_valid, s_data, s_kind, s_last and
//            observes every sequencer output.
//   slave  : the sequencer itself; consumes the coefficient stream and drives s_ready,
//            the weight-load port, the Q row-feed port, score_capture, busy and frame_err.
interface csd_feed_sequencer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 5
);
  // Input coefficient stream
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_kind;
  logic              s_last;
  // Weight-load port
  logic              load_weights;
  logic [DATA_W-1:0] v_in_data;
  logic [IDX_W-1:0]  v_idx;
  // Query-feed port
  logic              run_compute;
  logic              q_feed_vld;
  logic [IDX_W-1:0]  q_feed_row;
  logic [DATA_W-1:0] q_feed_data;
  // Status
  logic              score_capture;
  logic              busy;
  logic              frame_err;

  modport master (
    output s_valid, s_data, s_kind, s_last,
    input  s_ready, load_weights, v_in_data, v_idx, run_compute, q_feed_vld, q_feed_row,
           q_feed_data, score_capture, busy, frame_err
  );

  modport slave (
    input  s_valid, s_data, s_kind, s_last,
    output s_ready, load_weights, v_in_data, v_idx, run_compute, q_feed_vld, q_feed_row,
           q_feed_data, score_capture, busy, frame_err
  );
endinterface

// File: rtl/csd_feed_sequencer.sv
// Edge feeder for the Clifford systolic dataflow array.
// Turns one valid/ready stream of GA_DIM-beat multivector packets into:
//   - V packets: indexed weight writes (load_weights/v_in_data/v_idx), 1-cycle latency.
//   - Q packets: buffered, then issued one row per cycle (q_feed_*), followed by a
//     DRAIN_CYC wait and a one-cycle score_capture strobe.
// Ports:
//   clk  : clock, all state updates on the rising edge.
//   rst  : synchronous active-high reset.
//   bus  : csd_feed_sequencer_if.slave (stream in, weight/feed/status out).
// Build option CSD_FEED_DBUF_EN: ping/pong Q buffers so the next Q packet can be collected
// during FEED/DRAIN and fed straight after score_capture. Undefined: single buffer,
// stream stalled throughout FEED and DRAIN.
// Assumes GA_DIM >= 2 and DRAIN_CYC >= 2.
module csd_feed_sequencer #(
  parameter int unsigned GA_DIM    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned DRAIN_CYC = 64
) (
  input logic                 clk,
  input logic                 rst,
  csd_feed_sequencer_if.slave bus
);

  localparam int unsigned       DrainW    = $clog2(DRAIN_CYC);
  localparam logic [IDX_W-1:0]  BeatLast  = IDX_W'(GA_DIM - 1);
  localparam logic [IDX_W:0]    FeedEnd   = (IDX_W + 1)'(GA_DIM);
  localparam logic [IDX_W:0]    FeedOne   = (IDX_W + 1)'(1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYC - 1);
  localparam logic [DrainW-1:0] DrainCap  = DrainW'(DRAIN_CYC - 2);

  typedef enum logic [2:0] {StIdle, StLoadV, StCollectQ, StFeed, StDrain} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  beat_q;
  logic [IDX_W:0]    feed_q;   // next row to issue while in StFeed
  logic [DrainW-1:0] drain_q;
  logic              frame_err_q;
  logic              load_weights_q;
  logic [DATA_W-1:0] v_in_data_q;
  logic [IDX_W-1:0]  v_idx_q;
  logic              run_compute_q;
  logic              q_feed_vld_q;
  logic [IDX_W-1:0]  q_feed_row_q;
  logic [DATA_W-1:0] q_feed_data_q;
  logic              score_capture_q;

  logic              s_ready;
  logic              accept;
  logic              last_beat;
  logic              drain_done;
  logic              buf_we;
  logic              feed_start;
  logic [IDX_W-1:0]  rd_row;
  logic [DATA_W-1:0] rd_data;

  assign accept     = bus.s_valid && s_ready;
  assign last_beat  = (beat_q == BeatLast);
  assign drain_done = (state_q == StDrain) && (drain_q == DrainLast);
  // Row 0 is read while still collecting/draining, later rows while feeding.
  assign rd_row     = (state_q == StFeed) ? feed_q[IDX_W-1:0] : '0;

`ifdef CSD_FEED_DBUF_EN
  logic              wr_sel_q;     // buffer being collected into
  logic              rd_sel_q;     // buffer being fed
  logic              bg_active_q;  // Q packet partially collected during FEED/DRAIN
  logic              bg_full_q;    // complete Q packet waiting for the array
  logic [DATA_W-1:0] q_buf [2][GA_DIM];

  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      StIdle, StLoadV, StCollectQ: s_ready = 1'b1;
      // Only Q packets may start in the background, and only into a free buffer.
      StFeed, StDrain:             s_ready = !bg_full_q && (bg_active_q || !bus.s_kind);
      default:                     s_ready = 1'b0;
    endcase
  end

  assign buf_we = accept && ((state_q == StIdle && !bus.s_kind) ||
                             (state_q inside {StCollectQ, StFeed, StDrain}));

  // A background packet finishing on the final DRAIN cycle counts as complete.
  assign feed_start = (accept && last_beat && (state_q == StCollectQ)) ||
                      (drain_done && (bg_full_q || (accept && last_beat)));

  assign rd_data = q_buf[(state_q == StFeed) ? rd_sel_q : wr_sel_q][rd_row];

  always_ff @(posedge clk) begin
    if (buf_we) q_buf[wr_sel_q][beat_q] <= bus.s_data;
  end
`else
  logic [DATA_W-1:0] q_buf [GA_DIM];

  assign s_ready    = (state_q inside {StIdle, StLoadV, StCollectQ});
  assign buf_we     = accept && ((state_q == StIdle && !bus.s_kind) || state_q == StCollectQ);
  assign feed_start = accept && last_beat && (state_q == StCollectQ);
  assign rd_data    = q_buf[rd_row];

  always_ff @(posedge clk) begin
    if (buf_we) q_buf[beat_q] <= bus.s_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      beat_q          <= '0;
      feed_q          <= '0;
      drain_q         <= '0;
      frame_err_q     <= 1'b0;
      load_weights_q  <= 1'b0;
      v_in_data_q     <= '0;
      v_idx_q         <= '0;
      run_compute_q   <= 1'b0;
      q_feed_vld_q    <= 1'b0;
      q_feed_row_q    <= '0;
      q_feed_data_q   <= '0;
      score_capture_q <= 1'b0;
`ifdef CSD_FEED_DBUF_EN
      wr_sel_q        <= 1'b0;
      rd_sel_q        <= 1'b0;
      bg_active_q     <= 1'b0;
      bg_full_q       <= 1'b0;
`endif
    end else begin
      // Strobes and data outputs are zero unless set below.
      load_weights_q  <= 1'b0;
      v_in_data_q     <= '0;
      v_idx_q         <= '0;
      run_compute_q   <= 1'b0;
      q_feed_vld_q    <= 1'b0;
      q_feed_row_q    <= '0;
      q_feed_data_q   <= '0;
      score_capture_q <= 1'b0;

      // Framing is purely beat-count based; s_last only feeds the error flag.
      if (accept) begin
        beat_q <= last_beat ? '0 : beat_q + 1'b1;
        if (bus.s_last != last_beat) frame_err_q <= 1'b1;
      end

`ifdef CSD_FEED_DBUF_EN
      if (accept && (state_q == StFeed || state_q == StDrain)) begin
        bg_active_q <= !last_beat;
        if (last_beat) bg_full_q <= 1'b1;
      end
`endif

      case (state_q)
        StIdle: begin
          if (accept) begin
            if (bus.s_kind) begin
              state_q        <= StLoadV;
              load_weights_q <= 1'b1;
              v_in_data_q    <= bus.s_data;
              v_idx_q        <= beat_q;
            end else begin
              state_q <= StCollectQ;
            end
          end
        end
        StLoadV: begin
          if (accept) begin
            load_weights_q <= 1'b1;
            v_in_data_q    <= bus.s_data;
            v_idx_q        <= beat_q;
            if (last_beat) state_q <= StIdle;
          end
        end
        StCollectQ: begin
          // Leaves through feed_start on the last beat.
        end
        StFeed: begin
          if (feed_q == FeedEnd) begin
            state_q <= StDrain;
            drain_q <= '0;
          end else begin
            q_feed_vld_q  <= 1'b1;
            q_feed_row_q  <= feed_q[IDX_W-1:0];
            q_feed_data_q <= rd_data;
            feed_q        <= feed_q + 1'b1;
          end
        end
        StDrain: begin
          drain_q <= drain_q + 1'b1;
          if (drain_q == DrainCap) score_capture_q <= 1'b1;
          if (drain_done) begin
            state_q <= StIdle;
`ifdef CSD_FEED_DBUF_EN
            // An unfinished background packet continues in the foreground.
            if (bg_active_q || accept) state_q <= StCollectQ;
            bg_active_q <= 1'b0;
            bg_full_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase

      // Overrides any state choice above: row 0 goes out the cycle after the trigger.
      if (feed_start) begin
        state_q       <= StFeed;
        feed_q        <= FeedOne;
        q_feed_vld_q  <= 1'b1;
        q_feed_row_q  <= '0;
        q_feed_data_q <= rd_data;
        run_compute_q <= 1'b1;
`ifdef CSD_FEED_DBUF_EN
        rd_sel_q      <= wr_sel_q;
        wr_sel_q      <= !wr_sel_q;
`endif
      end
    end
  end

  assign bus.s_ready       = s_ready;
  assign bus.load_weights  = load_weights_q;
  assign bus.v_in_data     = v_in_data_q;
  assign bus.v_idx         = v_idx_q;
  assign bus.run_compute   = run_compute_q;
  assign bus.q_feed_vld    = q_feed_vld_q;
  assign bus.q_feed_row    = q_feed_row_q;
  assign bus.q_feed_data   = q_feed_data_q;
  assign bus.score_capture = score_capture_q;
  assign bus.busy          = (state_q != StIdle);
  assign bus.frame_err     = frame_err_q;

endmodule
